cpa_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit MG_CPA prefix adder among NREQ requesters. Each requester offers an (a, b) operand pair on a valid/ready handshake. The block grants one requester per cycle, drives the shared adder, and captures {cout, sum} with the winner's ID in a single-entry output register. It sits between the multiplier/accumulator front ends and the carry-propagate stage, so the adder's area is paid once.

---
 rtl/cpa_share_arb_if.sv | 44 ++++
 rtl/cpa_share_arb.sv | 183 ++++++++++++++++++
 tb/tb_cpa_share_arb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpa_share_arb_if.sv
// Handshake bundle between NREQ operand requesters and the shared adder.
// Requesters drive the master side; the arbiter takes the slave side.
interface cpa_share_arb_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_last;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_sum;
  logic               rsp_cout;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_last,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_sum,
    input  rsp_cout,
    input  rsp_id
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_last,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_sum,
    output rsp_cout,
    output rsp_id
  );
endinterface

// File: rtl/cpa_share_arb.sv
// Round-robin sharing of one MG_CPA prefix adder among NREQ requesters.
// Define CPA_SHARE_LOCK_EN to lock the grant across req_last bursts.
module MG_CPA (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g_k;
  logic [31:0] p_k;
  logic [31:0] g_n;
  logic [31:0] p_n;
  logic [31:0] p_0;
  logic [31:0] carry;

  // Kogge-Stone prefix tree: five doubling levels of (g, p) merges.
  always_comb begin
    g_k = a & b;
    p_k = a ^ b;
    p_0 = p_k;
    g_n = g_k;
    p_n = p_k;
    for (int k = 0; k < 5; k++) begin
      g_n = g_k;
      p_n = p_k;
      for (int i = (1 << k); i < 32; i++) begin
        g_n[i] = g_k[i] | (p_k[i] & g_k[i-(1<<k)]);
        p_n[i] = p_k[i] & p_k[i-(1<<k)];
      end
      g_k = g_n;
      p_k = p_n;
    end
    carry = {g_k[30:0], 1'b0};
    sum   = p_0 ^ carry;
    cout  = g_k[31];
  end
endmodule

module cpa_share_arb #(
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cpa_share_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  idx;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  sel_id;
  logic [IDW-1:0]  ptr_nxt;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            can_load;
  logic            accept;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic [31:0]     add_sum;
  logic            add_cout;
  logic            valid_q;
  logic [31:0]     sum_q;
  logic            cout_q;
  logic [IDW-1:0]  id_q;
  logic            hold_ptr;

`ifdef CPA_SHARE_LOCK_EN
  typedef enum logic {
    ST_OPEN,
    ST_LOCK
  } lock_st_t;

  lock_st_t       state_q;
  lock_st_t       state_d;
  logic [IDW-1:0] lock_id_q;
  logic [IDW-1:0] lock_id_d;
  logic           acc_last;

  assign acc_last = bus.req_last[gnt_id];

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OPEN;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Enter lock on a non-last beat, leave it on the holder's last beat.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    hold_ptr  = 1'b0;
    if (accept) begin
      if (!acc_last) begin
        state_d   = ST_LOCK;
        lock_id_d = gnt_id;
        hold_ptr  = 1'b1;
      end else begin
        state_d   = ST_OPEN;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;
  assign hold_ptr    = 1'b0;
`endif

  // First valid requester at or after ptr, wrapping; lock overrides.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      idx = IDW'((int'(ptr_q) + j) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
`ifdef CPA_SHARE_LOCK_EN
    if (state_q == ST_LOCK) begin
      gnt_id = lock_id_q;
      found  = bus.req_valid[lock_id_q];
    end
`endif
    if (found) grant[gnt_id] = 1'b1;
  end

  assign can_load      = !valid_q || bus.rsp_ready;
  assign bus.req_ready = grant & {NREQ{can_load}};
  assign accept        = found && can_load;
  assign sel_id        = found ? gnt_id : '0;
  assign ptr_nxt       = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  // Operand mux driven by the grant; idle cycles feed requester 0.
  always_comb begin
    op_a = bus.req_a[31:0];
    op_b = bus.req_b[31:0];
    for (int i = 0; i < NREQ; i++) begin
      if (sel_id == IDW'(i)) begin
        op_a = bus.req_a[32*i +: 32];
        op_b = bus.req_b[32*i +: 32];
      end
    end
  end

  MG_CPA u_cpa (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      sum_q   <= add_sum;
      cout_q  <= add_cout;
      id_q    <= gnt_id;
      if (!hold_ptr) ptr_q <= ptr_nxt;
    end else if (valid_q && bus.rsp_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = id_q;
endmodule

// File: tb/tb_cpa_share_arb.sv
// Directed scoreboard bench for cpa_share_arb with NREQ=4.
// Driver feeds per-requester beat lists; a monitor checks every result.
module tb_cpa_share_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cpa_share_arb_if #(.NREQ(4)) bus ();

  cpa_share_arb #(.NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic        cout;
    logic [31:0] sum;
  } rsp_t;

  rsp_t exp_q[$];
  int total = 0;
  int bad = 0;

  logic [31:0] bt_a [4][16];
  logic [31:0] bt_b [4][16];
  logic        bt_l [4][16];
  int head [4];
  int tail [4];
  logic [3:0] acc;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic add_beat(input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic l);
    bt_a[i][tail[i]] = a;
    bt_b[i][tail[i]] = b;
    bt_l[i][tail[i]] = l;
    tail[i]++;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic c,
                          input logic [31:0] s);
    rsp_t r;
    r.id = id;
    r.cout = c;
    r.sum = s;
    exp_q.push_back(r);
  endtask

  function automatic bit beats_empty();
    for (int i = 0; i < 4; i++)
      if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && beats_empty() && !bus.rsp_valid)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("idle_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) head[i] = tail[i];
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Requester model: present head beat, pop it once accepted.
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_last = '0;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready & {4{rst_n}};
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) head[i]++;
        if (head[i] != tail[i]) begin
          bus.req_valid[i] = 1'b1;
          bus.req_a[32*i +: 32] = bt_a[i][head[i]];
          bus.req_b[32*i +: 32] = bt_b[i][head[i]];
          bus.req_last[i] = bt_l[i][head[i]];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every handshaken result must match the scoreboard head.
  initial begin
    rsp_t got;
    rsp_t want;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        got.id = bus.rsp_id;
        got.cout = bus.rsp_cout;
        got.sum = bus.rsp_sum;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(got), 64'hdead_dead_dead);
        end else begin
          want = exp_q.pop_front();
          chk("rsp", 64'(got), 64'(want));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_sum", 64'(bus.rsp_sum), 64'd0);
    chk("rst_cout", 64'(bus.rsp_cout), 64'd0);
    chk("rst_id", 64'(bus.rsp_id), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Lone requester 2, carry out of the top bit.
    @(negedge clk);
    add_beat(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    push_exp(2'd2, 1'b1, 32'h0000_0000);
    @(negedge clk);
    chk("solo_ready", 64'(bus.req_ready), 64'h4);
    wait_idle();

    // All four valid: rotation 0,1,2,3,0.
    do_reset();
    @(negedge clk);
    add_beat(0, 32'h0000_0001, 32'h0000_0002, 1'b1);
    add_beat(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    add_beat(1, 32'h0000_0010, 32'h0000_0020, 1'b1);
    add_beat(2, 32'hFFFF_0000, 32'h0001_FFFF, 1'b1);
    add_beat(3, 32'h1234_5678, 32'h1111_1111, 1'b1);
    push_exp(2'd0, 1'b0, 32'h0000_0003);
    push_exp(2'd1, 1'b0, 32'h0000_0030);
    push_exp(2'd2, 1'b1, 32'h0000_FFFF);
    push_exp(2'd3, 1'b0, 32'h2345_6789);
    push_exp(2'd0, 1'b0, 32'h8000_0000);
    wait_idle();

    // Backpressure for 5 cycles, then back-to-back drain and accept.
    do_reset();
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    add_beat(0, 32'h0000_0005, 32'h0000_0006, 1'b1);
    add_beat(1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    add_beat(3, 32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
    push_exp(2'd0, 1'b0, 32'h0000_000B);
    push_exp(2'd1, 1'b1, 32'h0000_0000);
    push_exp(2'd3, 1'b0, 32'hDFAE_BFF0);
    @(negedge clk);
    @(negedge clk);
    repeat (5) begin
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_sum", 64'(bus.rsp_sum), 64'h0B);
      chk("bp_id", 64'(bus.rsp_id), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nobubble_valid", 64'(bus.rsp_valid), 64'd1);
    end
    wait_idle();

    // Reset while a result is pending discards it; waiter survives.
    do_reset();
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    add_beat(2, 32'h0000_0003, 32'h0000_0004, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("pend_valid", 64'(bus.rsp_valid), 64'd1);
    chk("pend_sum", 64'(bus.rsp_sum), 64'd7);
    add_beat(0, 32'h0000_0009, 32'h0000_0009, 1'b1);
    push_exp(2'd0, 1'b0, 32'h0000_0012);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_sum", 64'(bus.rsp_sum), 64'd0);
    chk("mid_rst_id", 64'(bus.rsp_id), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'h1);
    wait_idle();

    // Burst from requester 1 against requester 0, starting at ptr=1.
    do_reset();
    @(negedge clk);
    add_beat(0, 32'h0000_0007, 32'h0000_0008, 1'b1);
    push_exp(2'd0, 1'b0, 32'h0000_000F);
    wait_idle();
    @(negedge clk);
    add_beat(1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    add_beat(1, 32'h0000_0002, 32'h0000_0002, 1'b0);
    add_beat(1, 32'h0000_0003, 32'h0000_0003, 1'b1);
    add_beat(0, 32'hA000_0000, 32'h6000_0000, 1'b1);
    add_beat(0, 32'h0000_0064, 32'h0000_00C8, 1'b1);
`ifdef CPA_SHARE_LOCK_EN
    push_exp(2'd1, 1'b0, 32'h0000_0002);
    push_exp(2'd1, 1'b0, 32'h0000_0004);
    push_exp(2'd1, 1'b0, 32'h0000_0006);
    push_exp(2'd0, 1'b1, 32'h0000_0000);
    push_exp(2'd0, 1'b0, 32'h0000_012C);
`else
    push_exp(2'd1, 1'b0, 32'h0000_0002);
    push_exp(2'd0, 1'b1, 32'h0000_0000);
    push_exp(2'd1, 1'b0, 32'h0000_0004);
    push_exp(2'd0, 1'b0, 32'h0000_012C);
    push_exp(2'd1, 1'b0, 32'h0000_0006);
`endif
    wait_idle();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
